cp_mc_control_unit: RTL and testbench
=====================================

Name: cp_mc_control_unit

Overview:
- Multi-cycle, parametrised successor of the coprocessor control decoder.
- Accepts one opcode per valid/ready handshake and decodes it into the coprocessor datapath control bundle.
- Sequences the instruction through DECODE, EXEC, MEM and WB phases.
- Waits on a multi-cycle ALU and on memory handshakes; the datapath sees registered, phase-qualified strobes.

Parameters:
- OPW, 6, opcode width. Must be ≥6. Class decode uses opcode[OPW-1:OPW-6]; the full opcode is forwarded to alu_opcode.
- MC_BIT, 3, bit index within the 6-bit class field. ALU-immediate opcodes (10????) with this bit set are multi-cycle and wait for alu_done.
- WAIT_MAX, 15, maximum cycles spent waiting on alu_done or mem_ack before the instruction aborts.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  opcode is valid.
- instr_ready  out  1  block can accept an opcode.
- opcode  in  OPW  instruction opcode.
- alu_start  out  1  one-cycle ALU start pulse.
- alu_done  in  1  multi-cycle ALU result ready.
- mem_req  out  1  memory request, held until acknowledged.
- mem_ack  in  1  memory acknowledge.
- alu_opcode  out  OPW  latched opcode.
- reg_src, reg_dst, alu_src1, alu_src2  out  1 each  static datapath selects.
- reg_write, mem_write, reg_write_from_mem  out  1 each  write strobes.
- busy  out  1  instruction in flight.
- illegal  out  1  one-cycle pulse on an undefined class or a timeout.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0 except instr_ready=1.
  - alu_opcode=0, wait counter=0.
- Reset mid-instruction aborts it immediately; no strobe completes.
- IDLE:
  - instr_ready=1, busy=0.
  - When instr_valid && instr_ready, latch opcode and go to DECODE.
- DECODE (1 cycle):
  - Register the selects from the class field:
    - 10????: alu_src2=1.
    - 110000: alu_src2=1.
    - 110001 / 110010: reg_src=1, alu_src1=1.
    - 110011 (load): reg_src=1, reg_dst=1.
    - 110100 (store): reg_src=1.
  - Next state: ALU classes → EXEC; load/store → MEM.
  - Any other class → illegal=1 for 1 cycle, then IDLE with no strobes.
- EXEC:
  - alu_start=1 in the first EXEC cycle only.
  - Single-cycle op: go to WB after 1 cycle.
  - Multi-cycle op: stay until alu_done=1, then WB.
  - alu_done is ignored for single-cycle ops.
- MEM:
  - mem_req=1 continuously.
  - Store: mem_write=1 while in MEM; on mem_ack go to IDLE.
  - Load: on mem_ack go to WB.
  - mem_ack sampled in the first MEM cycle is valid (zero-wait memory).
- WB (1 cycle):
  - ALU op: reg_write=1.
  - Load: reg_write_from_mem=1, reg_write=0.
  - Next state IDLE.
- Timeout:
  - The wait counter increments every cycle spent in multi-cycle EXEC or in MEM, and clears on state change.
  - When the counter reaches WAIT_MAX without done/ack: illegal=1, no write strobe, go to IDLE.
  - If done/ack arrives in the same cycle the counter reaches WAIT_MAX, done/ack wins.
- Selects hold from DECODE until the return to IDLE, then clear to 0. alu_opcode holds until the next accept.
- busy = (state != IDLE).
- Latency, handshake cycle = 0:
  - Single-cycle ALU: reg_write at cycle 3; next accept at cycle 4.
  - Store with zero-wait ack: ready at cycle 3.

Optional Feature:
- Macro: CP_MC_PERF_CNT_EN.
- Defined:
  - Adds outputs retired_cnt[31:0] and stall_cnt[31:0], reset to 0, both wrapping at 2^32.
  - retired_cnt increments on each non-illegal return to IDLE.
  - stall_cnt increments on each cycle spent waiting in EXEC or MEM beyond the first.
- Undefined: no counters and no extra ports; all other behaviour is identical.

Decomposition:
- Package cp_ctrl_pkg:
  - State enum: IDLE, DECODE, EXEC, MEM, WB.
  - Class opcode constants: CLS_ALU_IMM_PFX, OP_IMM, OP_REG1, OP_REG2, OP_LOAD, OP_STORE.
  - Struct for the select bundle.
- Sub-module cp_ctrl_decode: purely combinational class-field-to-select-bundle decode, plus is_alu, is_mem, is_load, is_multicycle and is_illegal flags. The FSM instantiates it once.

Test Plan:
- Single-cycle ALU: opcode 110000 with valid at cycle 0 → alu_start at cycle 2, reg_write at cycle 3 with alu_src2=1, instr_ready=1 at cycle 4.
- Multi-cycle ALU: opcode 101000, alu_done at cycle 6 → reg_write at cycle 7; busy=1 for cycles 1–7.
- Load with mem_ack 3 cycles late → mem_req held 4 cycles, reg_write_from_mem=1 for 1 cycle, reg_write=0 throughout.
- Store with zero-wait ack: opcode 110100 → mem_write and mem_req high for exactly 1 cycle, no WB, ready at cycle 3.
- Faults:
  - Opcode 111111 → illegal pulse in DECODE, no strobes.
  - Multi-cycle ALU with alu_done never asserted → illegal after WAIT_MAX=15 wait cycles, no reg_write.
- rst_n low during MEM → all outputs 0 asynchronously; after release, instr_ready=1 and the next opcode is processed normally.

Source files
------------

// File: rtl/cp_ctrl_pkg.sv
// Shared types and class-field constants for the multi-cycle coprocessor control unit.
// Used by cp_ctrl_decode and cp_mc_control_unit.
package cp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  // Class field is the top 6 opcode bits; ALU-immediate is any 10???? class
  localparam logic [1:0] CLS_ALU_IMM_PFX = 2'b10;
  localparam logic [5:0] OP_IMM   = 6'b110000;
  localparam logic [5:0] OP_REG1  = 6'b110001;
  localparam logic [5:0] OP_REG2  = 6'b110010;
  localparam logic [5:0] OP_LOAD  = 6'b110011;
  localparam logic [5:0] OP_STORE = 6'b110100;

  typedef struct packed {
    logic reg_src;
    logic reg_dst;
    logic alu_src1;
    logic alu_src2;
  } sel_t;

endpackage

// File: rtl/cp_ctrl_decode.sv
// Combinational class-field decode: datapath select bundle plus instruction-kind flags.
module cp_ctrl_decode
  import cp_ctrl_pkg::*;
#(
  parameter int MC_BIT = 3
) (
  input  logic [5:0] cls,
  output sel_t       sel,
  output logic       is_alu,
  output logic       is_mem,
  output logic       is_load,
  output logic       is_multicycle,
  output logic       is_illegal
);

  always_comb begin
    sel           = '0;
    is_alu        = 1'b0;
    is_mem        = 1'b0;
    is_load       = 1'b0;
    is_multicycle = 1'b0;
    is_illegal    = 1'b0;
    if (cls[5:4] == CLS_ALU_IMM_PFX) begin
      sel.alu_src2  = 1'b1;
      is_alu        = 1'b1;
      is_multicycle = cls[MC_BIT];
    end else begin
      case (cls)
        OP_IMM: begin
          sel.alu_src2 = 1'b1;
          is_alu       = 1'b1;
        end
        OP_REG1, OP_REG2: begin
          sel.reg_src  = 1'b1;
          sel.alu_src1 = 1'b1;
          is_alu       = 1'b1;
        end
        OP_LOAD: begin
          sel.reg_src = 1'b1;
          sel.reg_dst = 1'b1;
          is_mem      = 1'b1;
          is_load     = 1'b1;
        end
        OP_STORE: begin
          sel.reg_src = 1'b1;
          is_mem      = 1'b1;
        end
        default: is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/cp_mc_control_unit.sv
// Multi-cycle coprocessor control unit: DECODE/EXEC/MEM/WB sequencing with ALU and memory waits.
// Optional performance counters enabled by defining CP_MC_PERF_CNT_EN.
module cp_mc_control_unit
  import cp_ctrl_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int MC_BIT   = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] opcode,
  output logic           alu_start,
  input  logic           alu_done,
  output logic           mem_req,
  input  logic           mem_ack,
  output logic [OPW-1:0] alu_opcode,
  output logic           reg_src,
  output logic           reg_dst,
  output logic           alu_src1,
  output logic           alu_src2,
  output logic           reg_write,
  output logic           mem_write,
  output logic           reg_write_from_mem,
  output logic           busy,
  output logic           illegal
`ifdef CP_MC_PERF_CNT_EN
  ,
  output logic [31:0]    retired_cnt,
  output logic [31:0]    stall_cnt
`endif
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

  state_t         state, next_state;
  logic [OPW-1:0] op_q;
  logic [CW-1:0]  wait_cnt;
  sel_t           sel_q, d_sel;
  logic           d_alu, d_mem, d_load, d_mc, d_illegal;
  logic           waiting, done_ev, timeout;

  // Latched opcode is stable from accept to the next accept, so decoding it live is safe
  cp_ctrl_decode #(
    .MC_BIT (MC_BIT)
  ) u_decode (
    .cls           (op_q[OPW-1 -: 6]),
    .sel           (d_sel),
    .is_alu        (d_alu),
    .is_mem        (d_mem),
    .is_load       (d_load),
    .is_multicycle (d_mc),
    .is_illegal    (d_illegal)
  );

  assign waiting = (state == EXEC && d_mc) || (state == MEM);
  assign done_ev = (state == EXEC && d_mc && alu_done) || (state == MEM && mem_ack);
  assign timeout = waiting && !done_ev && (wait_cnt == CNT_MAX);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (instr_valid) next_state = DECODE;
      DECODE: begin
        if (d_illegal)  next_state = IDLE;
        else if (d_alu) next_state = EXEC;
        else if (d_mem) next_state = MEM;
        else            next_state = IDLE;
      end
      EXEC: begin
        if (!d_mc || alu_done) next_state = WB;
        else if (timeout)      next_state = IDLE;
      end
      MEM: begin
        if (mem_ack)      next_state = d_load ? WB : IDLE;
        else if (timeout) next_state = IDLE;
      end
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      sel_q    <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && instr_valid) op_q <= opcode;
      if (next_state != state)                wait_cnt <= '0;
      else if (waiting && wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CW'(1);
      if (state == DECODE)          sel_q <= d_sel;
      else if (next_state == IDLE)  sel_q <= '0;
    end
  end

`ifdef CP_MC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (state == WB || (state == MEM && mem_ack && !d_load))
        retired_cnt <= retired_cnt + 32'd1;
      if (waiting && wait_cnt != '0)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  // wait_cnt is zero only in the first EXEC cycle, which marks the start pulse
  assign alu_start          = (state == EXEC) && (wait_cnt == '0);
  assign instr_ready        = (state == IDLE);
  assign busy               = (state != IDLE);
  assign mem_req            = (state == MEM);
  assign mem_write          = (state == MEM) && !d_load;
  assign reg_write          = (state == WB) && !d_load;
  assign reg_write_from_mem = (state == WB) && d_load;
  assign illegal            = (state == DECODE && d_illegal) || timeout;
  assign alu_opcode         = op_q;
  assign reg_src            = sel_q.reg_src;
  assign reg_dst            = sel_q.reg_dst;
  assign alu_src1           = sel_q.alu_src1;
  assign alu_src2           = sel_q.alu_src2;

endmodule

// File: tb/tb_cp_mc_control_unit.sv
// Directed self-checking bench for cp_mc_control_unit (default parameters).
module tb_cp_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_ready;
  logic [5:0] opcode;
  logic       alu_start, alu_done, mem_req, mem_ack;
  logic [5:0] alu_opcode;
  logic       reg_src, reg_dst, alu_src1, alu_src2;
  logic       reg_write, mem_write, reg_write_from_mem, busy, illegal;
`ifdef CP_MC_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // {ready, busy, alu_start, mem_req, mem_write, reg_write, rwfm, illegal, reg_src, reg_dst, alu_src1, alu_src2}
  logic [11:0] outs;
  assign outs = {instr_ready, busy, alu_start, mem_req, mem_write, reg_write,
                 reg_write_from_mem, illegal, reg_src, reg_dst, alu_src1, alu_src2};

  always #5 clk = ~clk;

  cp_mc_control_unit #(
    .OPW      (6),
    .MC_BIT   (3),
    .WAIT_MAX (15)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .opcode             (opcode),
    .alu_start          (alu_start),
    .alu_done           (alu_done),
    .mem_req            (mem_req),
    .mem_ack            (mem_ack),
    .alu_opcode         (alu_opcode),
    .reg_src            (reg_src),
    .reg_dst            (reg_dst),
    .alu_src1           (alu_src1),
    .alu_src2           (alu_src2),
    .reg_write          (reg_write),
    .mem_write          (mem_write),
    .reg_write_from_mem (reg_write_from_mem),
    .busy               (busy),
    .illegal            (illegal)
`ifdef CP_MC_PERF_CNT_EN
    ,
    .retired_cnt        (retired_cnt),
    .stall_cnt          (stall_cnt)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; alu_done = 1'b0; mem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (outs !== 12'h800) begin
      errors++; $display("FAIL reset_outs got %h expected %h", outs, 12'h800);
    end
    checks++;
    if (alu_opcode !== 6'h00) begin
      errors++; $display("FAIL reset_alu_opcode got %h expected %h", alu_opcode, 6'h00);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Single-cycle ALU: start at c2, reg_write at c3, ready again at c4
  task automatic test_single_alu();
    logic [11:0] exp;
    for (int c = 0; c < 5; c++) begin
      instr_valid = (c == 0); opcode = 6'b110000;
      alu_done = (c >= 1 && c <= 3);
      case (c)
        0: exp = 12'h800;
        1: exp = 12'h400;
        2: exp = 12'h601;
        3: exp = 12'h441;
        default: exp = 12'h800;
      endcase
      #1;
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL single_alu c%0d outs got %h expected %h", c, outs, exp);
      end
      @(negedge clk);
    end
    alu_done = 1'b0;
    checks++;
    if (alu_opcode !== 6'b110000) begin
      errors++; $display("FAIL single_alu_opcode got %h expected %h", alu_opcode, 6'b110000);
    end
  endtask

  // Multi-cycle ALU 101000; done_at < 0 means alu_done never comes (timeout at c17)
  task automatic test_mc(input string name, input int done_at, input int ncyc);
    logic [11:0] exp;
    for (int c = 0; c < ncyc; c++) begin
      instr_valid = (c == 0); opcode = 6'b101000;
      alu_done = (c == done_at);
      if (c == 0)      exp = 12'h800;
      else if (c == 1) exp = 12'h400;
      else if (c == 2) exp = 12'h601;
      else if (done_at >= 0) begin
        if (c <= done_at)          exp = 12'h401;
        else if (c == done_at + 1) exp = 12'h441;
        else                       exp = 12'h800;
      end else begin
        if (c <= 16)       exp = 12'h401;
        else if (c == 17)  exp = 12'h411;
        else               exp = 12'h800;
      end
      #1;
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s c%0d outs got %h expected %h", name, c, outs, exp);
      end
      @(negedge clk);
    end
    alu_done = 1'b0;
  endtask

  // Load (110011) or store (110100) with mem_ack raised at cycle ack_at
  task automatic test_mem(input string name, input logic is_load, input int ack_at, input int ncyc);
    logic [11:0] exp;
    logic [11:0] mem_exp;
    mem_exp = is_load ? 12'h50C : 12'h588;
    for (int c = 0; c < ncyc; c++) begin
      instr_valid = (c == 0); opcode = is_load ? 6'b110011 : 6'b110100;
      mem_ack = (c == ack_at);
      if (c == 0)                          exp = 12'h800;
      else if (c == 1)                     exp = 12'h400;
      else if (c <= ack_at)                exp = mem_exp;
      else if (is_load && c == ack_at + 1) exp = 12'h42C;
      else                                 exp = 12'h800;
      #1;
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s c%0d outs got %h expected %h", name, c, outs, exp);
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_illegal();
    logic [11:0] exp;
    for (int c = 0; c < 3; c++) begin
      instr_valid = (c == 0); opcode = 6'b111111;
      case (c)
        0: exp = 12'h800;
        1: exp = 12'h410;
        default: exp = 12'h800;
      endcase
      #1;
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL illegal_op c%0d outs got %h expected %h", c, outs, exp);
      end
      @(negedge clk);
    end
  endtask

  // Valid held high while busy; second opcode accepted only at c4
  task automatic test_back_to_back();
    logic [11:0] exp;
    for (int c = 0; c < 9; c++) begin
      instr_valid = (c <= 4);
      opcode = (c < 4) ? 6'b110001 : 6'b110010;
      case (c)
        0, 4, 8: exp = 12'h800;
        1, 5:    exp = 12'h400;
        2, 6:    exp = 12'h60A;
        default: exp = 12'h44A;
      endcase
      #1;
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL back_to_back c%0d outs got %h expected %h", c, outs, exp);
      end
      if (c == 2 || c == 6) begin
        checks++;
        if (alu_opcode !== ((c == 2) ? 6'b110001 : 6'b110010)) begin
          errors++; $display("FAIL back_to_back_opcode c%0d got %h", c, alu_opcode);
        end
      end
      @(negedge clk);
    end
  endtask

  // Reset asserted while a load sits in MEM, then a normal store follows
  task automatic test_reset_mid_mem();
    for (int c = 0; c < 4; c++) begin
      instr_valid = (c == 0); opcode = 6'b110011; mem_ack = 1'b0;
      #1;
      if (c == 3) begin
        checks++;
        if (outs !== 12'h50C) begin
          errors++; $display("FAIL rst_mid_pre outs got %h expected %h", outs, 12'h50C);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 12'h800) begin
          errors++; $display("FAIL rst_mid_async outs got %h expected %h", outs, 12'h800);
        end
        checks++;
        if (alu_opcode !== 6'h00) begin
          errors++; $display("FAIL rst_mid_opcode got %h expected %h", alu_opcode, 6'h00);
        end
      end
      @(negedge clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_mem("rst_recover_store", 1'b0, 2, 4);
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_mc("mc_alu", 6, 9);
    test_mem("load_late", 1'b1, 5, 8);
    test_mem("store_zero_wait", 1'b0, 2, 4);
    test_illegal();
    test_mc("mc_timeout", -1, 19);
    test_mc("mc_done_at_limit", 17, 20);
    test_mem("store_ack_at_limit", 1'b0, 17, 19);
    test_back_to_back();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
